// File: rtl/tank_pkg.sv
// Shared tank-game types and screen constants used by the bullet, tank movement and colour mapper blocks.
package tank_pkg;

    typedef enum logic [2:0] {
        DIR_UP    = 3'b001,
        DIR_RIGHT = 3'b010,
        DIR_LEFT  = 3'b011,
        DIR_DOWN  = 3'b100
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLYING   = 2'd1,
        ST_COOLDOWN = 2'd2
    } bullet_state_t;

    localparam logic [9:0] SCREEN_W  = 10'd640;
    localparam logic [9:0] SCREEN_H  = 10'd480;
    localparam logic [9:0] TANK_SIZE = 10'd32;

    // Signed working width for positions that may step past either screen edge.
    typedef logic signed [11:0] spos_t;

    function automatic spos_t to_spos(input logic [9:0] v);
        return spos_t'({2'b00, v});
    endfunction

endpackage

// File: rtl/rect_overlap.sv
// Axis-aligned overlap test between two half-open rectangles given by top-left corner and size.
module rect_overlap (
    input  logic [9:0] a_x,
    input  logic [9:0] a_y,
    input  logic [9:0] a_w,
    input  logic [9:0] a_h,
    input  logic [9:0] b_x,
    input  logic [9:0] b_y,
    input  logic [9:0] b_w,
    input  logic [9:0] b_h,
    output logic       overlap
);

    logic [10:0] a_x_end_s;
    logic [10:0] a_y_end_s;
    logic [10:0] b_x_end_s;
    logic [10:0] b_y_end_s;

    // Far edges are formed one bit wider so a box near 1023 cannot wrap.
    always_comb begin
        a_x_end_s = {1'b0, a_x} + {1'b0, a_w};
        a_y_end_s = {1'b0, a_y} + {1'b0, a_h};
        b_x_end_s = {1'b0, b_x} + {1'b0, b_w};
        b_y_end_s = {1'b0, b_y} + {1'b0, b_h};
        overlap   = ({1'b0, a_x} < b_x_end_s) && ({1'b0, b_x} < a_x_end_s) &&
                    ({1'b0, a_y} < b_y_end_s) && ({1'b0, b_y} < a_y_end_s);
    end

endmodule

// File: rtl/bullet_controller.sv
// Per-player projectile engine: launches a bullet from the tank muzzle on a fire press,
// steps it once per frame, and retires it at the screen edge or on striking the opposing tank.
module bullet_controller
    import tank_pkg::*;
#(
    parameter logic [9:0] BULLET_SIZE     = 10'd8,
    parameter logic [9:0] SPEED           = 10'd4,
    parameter logic [9:0] X_MAX           = SCREEN_W - 10'd1,
    parameter logic [9:0] Y_MAX           = SCREEN_H - 10'd1,
    parameter logic [5:0] COOLDOWN_FRAMES = 6'd15
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       fire,
    input  logic [2:0] tank_dir,
    input  logic [9:0] tankX,
    input  logic [9:0] tankY,
    input  logic [9:0] targetX,
    input  logic [9:0] targetY,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic [9:0] bullet_X,
    output logic [9:0] bullet_Y,
    output logic       is_bullet,
    output logic       is_shooting,
    output logic       hit
);

    localparam logic [9:0] SPAWN_OFS = (TANK_SIZE - BULLET_SIZE) >> 1'b1;

    bullet_state_t state_r;
    logic [2:0]    dir_r;
    logic          pending_r;
    logic [5:0]    cooldown_r;
    logic          frame_clk_q_r;
    logic          fire_q_r;

    logic          tick_s;
    logic          fire_rise_s;
    logic          req_s;
    spos_t         spawn_x_s;
    spos_t         spawn_y_s;
    logic          spawn_dir_ok_s;
    logic          spawn_ok_s;
    spos_t         next_x_s;
    spos_t         next_y_s;
    logic          next_oob_s;
    logic [9:0]    hit_x_s;
    logic [9:0]    hit_y_s;
    logic [9:0]    hit_w_s;
    logic [9:0]    hit_h_s;
    logic          hit_s;
    logic [10:0]   bx_end_s;
    logic [10:0]   by_end_s;

    function automatic logic on_screen(input spos_t x, input spos_t y);
        return !x[11] && !y[11] &&
               (x + to_spos(BULLET_SIZE) - 12'sd1 <= to_spos(X_MAX)) &&
               (y + to_spos(BULLET_SIZE) - 12'sd1 <= to_spos(Y_MAX));
    endfunction

    // Edge detection on the frame strobe and the fire key.
    always_comb begin
        tick_s      = frame_clk & ~frame_clk_q_r;
        fire_rise_s = fire & ~fire_q_r;
        req_s       = pending_r | fire_rise_s;
    end

    // Muzzle position for the current heading and whether a bullet fits there.
    always_comb begin
        spawn_x_s      = to_spos(tankX);
        spawn_y_s      = to_spos(tankY);
        spawn_dir_ok_s = 1'b1;
        case (tank_dir)
            DIR_UP: begin
                spawn_x_s = to_spos(tankX) + to_spos(SPAWN_OFS);
                spawn_y_s = to_spos(tankY) - to_spos(BULLET_SIZE);
            end
            DIR_DOWN: begin
                spawn_x_s = to_spos(tankX) + to_spos(SPAWN_OFS);
                spawn_y_s = to_spos(tankY) + to_spos(TANK_SIZE);
            end
            DIR_LEFT: begin
                spawn_x_s = to_spos(tankX) - to_spos(BULLET_SIZE);
                spawn_y_s = to_spos(tankY) + to_spos(SPAWN_OFS);
            end
            DIR_RIGHT: begin
                spawn_x_s = to_spos(tankX) + to_spos(TANK_SIZE);
                spawn_y_s = to_spos(tankY) + to_spos(SPAWN_OFS);
            end
            default: spawn_dir_ok_s = 1'b0;
        endcase
        spawn_ok_s = spawn_dir_ok_s & on_screen(spawn_x_s, spawn_y_s);
    end

    // Candidate position one step along the latched heading.
    always_comb begin
        next_x_s = to_spos(bullet_X);
        next_y_s = to_spos(bullet_Y);
        case (dir_r)
            DIR_UP:    next_y_s = to_spos(bullet_Y) - to_spos(SPEED);
            DIR_DOWN:  next_y_s = to_spos(bullet_Y) + to_spos(SPEED);
            DIR_LEFT:  next_x_s = to_spos(bullet_X) - to_spos(SPEED);
            DIR_RIGHT: next_x_s = to_spos(bullet_X) + to_spos(SPEED);
            default: begin
                next_x_s = to_spos(bullet_X);
                next_y_s = to_spos(bullet_Y);
            end
        endcase
        next_oob_s = !on_screen(next_x_s, next_y_s);
    end

    // A box poking past 0 is clipped to its visible part; the 10-bit wrap of the
    // negative coordinate added to the size yields exactly the remaining width.
    always_comb begin
        if (next_x_s[11]) begin
            hit_x_s = 10'd0;
            hit_w_s = BULLET_SIZE + next_x_s[9:0];
        end else begin
            hit_x_s = next_x_s[9:0];
            hit_w_s = BULLET_SIZE;
        end
        if (next_y_s[11]) begin
            hit_y_s = 10'd0;
            hit_h_s = BULLET_SIZE + next_y_s[9:0];
        end else begin
            hit_y_s = next_y_s[9:0];
            hit_h_s = BULLET_SIZE;
        end
    end

    rect_overlap u_hit_check (
        .a_x     (hit_x_s),
        .a_y     (hit_y_s),
        .a_w     (hit_w_s),
        .a_h     (hit_h_s),
        .b_x     (targetX),
        .b_y     (targetY),
        .b_w     (TANK_SIZE),
        .b_h     (TANK_SIZE),
        .overlap (hit_s)
    );

    // Bullet life cycle; all transitions happen only on a frame tick.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_r       <= ST_IDLE;
            dir_r         <= 3'b000;
            pending_r     <= 1'b0;
            cooldown_r    <= 6'd0;
            frame_clk_q_r <= 1'b0;
            fire_q_r      <= 1'b0;
            bullet_X      <= 10'd0;
            bullet_Y      <= 10'd0;
            hit           <= 1'b0;
        end else begin
            frame_clk_q_r <= frame_clk;
            fire_q_r      <= fire;
            hit           <= 1'b0;

            if (tick_s && (state_r == ST_IDLE) && req_s) begin
                pending_r <= 1'b0;
            end else if (fire_rise_s && (state_r != ST_COOLDOWN)) begin
                pending_r <= 1'b1;
            end

            if (tick_s) begin
                case (state_r)
                    ST_IDLE: begin
                        if (req_s && spawn_ok_s) begin
                            state_r  <= ST_FLYING;
                            dir_r    <= tank_dir;
                            bullet_X <= spawn_x_s[9:0];
                            bullet_Y <= spawn_y_s[9:0];
                        end
                    end
                    ST_FLYING: begin
                        if (hit_s) begin
                            hit        <= 1'b1;
                            state_r    <= ST_COOLDOWN;
                            cooldown_r <= COOLDOWN_FRAMES;
                            bullet_X   <= hit_x_s;
                            bullet_Y   <= hit_y_s;
                        end else if (next_oob_s) begin
                            state_r <= ST_IDLE;
                        end else begin
                            bullet_X <= next_x_s[9:0];
                            bullet_Y <= next_y_s[9:0];
                        end
                    end
                    ST_COOLDOWN: begin
                        if (cooldown_r <= 6'd1) begin
                            state_r    <= ST_IDLE;
                            cooldown_r <= 6'd0;
                        end else begin
                            cooldown_r <= cooldown_r - 6'd1;
                        end
                    end
                    default: state_r <= ST_IDLE;
                endcase
            end
        end
    end

    // Pixel coverage and status for the colour mapper.
    always_comb begin
        bx_end_s    = {1'b0, bullet_X} + {1'b0, BULLET_SIZE};
        by_end_s    = {1'b0, bullet_Y} + {1'b0, BULLET_SIZE};
        is_shooting = (state_r == ST_FLYING);
        is_bullet   = is_shooting &&
                      (DrawX >= bullet_X) && ({1'b0, DrawX} < bx_end_s) &&
                      (DrawY >= bullet_Y) && ({1'b0, DrawY} < by_end_s);
    end

endmodule

// File: tb/tb_bullet_controller.sv
// Directed bench for bullet_controller: launch, flight, edge retirement, hits, cooldown and reset.
module tb_bullet_controller;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic       fire = 1'b0;
    logic [2:0] tank_dir = 3'b001;
    logic [9:0] tankX = 10'd100;
    logic [9:0] tankY = 10'd200;
    logic [9:0] targetX = 10'd400;
    logic [9:0] targetY = 10'd400;
    logic [9:0] DrawX = 10'd0;
    logic [9:0] DrawY = 10'd0;
    logic [9:0] bullet_X;
    logic [9:0] bullet_Y;
    logic       is_bullet;
    logic       is_shooting;
    logic       hit;

    int checks_n = 0;
    int errors_n = 0;
    int hit_cnt  = 0;
    int pix_cnt  = 0;

    bullet_controller dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_clk   (frame_clk),
        .fire        (fire),
        .tank_dir    (tank_dir),
        .tankX       (tankX),
        .tankY       (tankY),
        .targetX     (targetX),
        .targetY     (targetY),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .bullet_X    (bullet_X),
        .bullet_Y    (bullet_Y),
        .is_bullet   (is_bullet),
        .is_shooting (is_shooting),
        .hit         (hit)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_n++;
        if (got !== exp) begin
            errors_n++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One frame strobe; counts Clk cycles on which hit is seen high.
    task automatic tick();
        @(negedge Clk) frame_clk = 1'b1;
        repeat (3) begin
            @(negedge Clk);
            if (hit === 1'b1) hit_cnt++;
        end
        frame_clk = 1'b0;
        repeat (2) begin
            @(negedge Clk);
            if (hit === 1'b1) hit_cnt++;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press();
        @(negedge Clk) fire = 1'b1;
        @(negedge Clk) fire = 1'b0;
        @(negedge Clk);
    endtask

    task automatic do_reset();
        @(negedge Clk) Reset_n = 1'b0;
        @(negedge Clk) Reset_n = 1'b1;
    endtask

    // Counts is_bullet over a 48x48 pixel window starting at (x0,y0).
    task automatic scan(input int x0, input int y0);
        pix_cnt = 0;
        @(negedge Clk);
        for (int dy = 0; dy < 48; dy++) begin
            for (int dx = 0; dx < 48; dx++) begin
                DrawX = 10'(x0 + dx);
                DrawY = 10'(y0 + dy);
                #1;
                if (is_bullet === 1'b1) pix_cnt++;
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        check_eq("reset_shooting", is_shooting, 1'b0);
        check_eq("reset_bx", bullet_X, 10'd0);
        check_eq("reset_by", bullet_Y, 10'd0);
        check_eq("reset_hit", hit, 1'b0);
        Reset_n = 1'b1;

        // Launch upward and fly; later heading/position changes must not steer it.
        tankX = 10'd100; tankY = 10'd200; tank_dir = 3'b001;
        press();
        hit_cnt = 0;
        tick();
        check_eq("up_launch_shooting", is_shooting, 1'b1);
        check_eq("up_spawn_x", bullet_X, 10'd112);
        check_eq("up_spawn_y", bullet_Y, 10'd192);
        tank_dir = 3'b100; tankX = 10'd300;
        ticks(2);
        check_eq("up_fly_x", bullet_X, 10'd112);
        check_eq("up_fly_y", bullet_Y, 10'd184);
        check_eq("up_fly_nohit", hit_cnt, 0);
        scan(96, 168);
        check_eq("raster_64", pix_cnt, 64);

        // One-cycle reset mid-flight.
        @(negedge Clk) Reset_n = 1'b0;
        @(negedge Clk) Reset_n = 1'b1;
        check_eq("midreset_shooting", is_shooting, 1'b0);
        check_eq("midreset_bx", bullet_X, 10'd0);
        check_eq("midreset_by", bullet_Y, 10'd0);
        check_eq("midreset_hit", hit, 1'b0);

        // Spawn rejected at the right edge; the dropped request must not linger.
        tankX = 10'd601; tankY = 10'd100; tank_dir = 3'b010;
        press(); tick();
        check_eq("right_spawn_oob", is_shooting, 1'b0);
        tankX = 10'd500;
        tick();
        check_eq("dropped_not_pending", is_shooting, 1'b0);
        tankX = 10'd100; tankY = 10'd5; tank_dir = 3'b001;
        press(); tick();
        check_eq("up_spawn_underflow", is_shooting, 1'b0);
        tankY = 10'd200; tank_dir = 3'b000;
        press(); tick();
        check_eq("invalid_dir", is_shooting, 1'b0);
        tank_dir = 3'b001;
        tick();
        check_eq("invalid_dir_dropped", is_shooting, 1'b0);
        tankY = 10'd8;
        press(); tick();
        check_eq("spawn_y0_ok", is_shooting, 1'b1);
        check_eq("spawn_y0_y", bullet_Y, 10'd0);
        hit_cnt = 0;
        tick();
        check_eq("top_edge_retire", is_shooting, 1'b0);
        check_eq("top_edge_nohit", hit_cnt, 0);

        // Rightward flight up to the right edge.
        tankX = 10'd589; tankY = 10'd100; tank_dir = 3'b010;
        press(); tick();
        check_eq("right_spawn_x", bullet_X, 10'd621);
        check_eq("right_spawn_y", bullet_Y, 10'd112);
        ticks(2);
        check_eq("right_629_flying", is_shooting, 1'b1);
        check_eq("right_629_x", bullet_X, 10'd629);
        hit_cnt = 0;
        tick();
        check_eq("right_edge_retire", is_shooting, 1'b0);
        check_eq("right_edge_nohit", hit_cnt, 0);
        scan(613, 96);
        check_eq("idle_no_pixels", pix_cnt, 0);

        // Hit on the target, then a 15-tick cooldown that discards fire.
        targetX = 10'd140; targetY = 10'd190;
        tankX = 10'd92; tankY = 10'd192; tank_dir = 3'b010;
        press(); tick();
        check_eq("hit_spawn_x", bullet_X, 10'd124);
        check_eq("hit_spawn_y", bullet_Y, 10'd204);
        hit_cnt = 0;
        ticks(2);
        check_eq("pre_hit_x", bullet_X, 10'd132);
        check_eq("pre_hit_nohit", hit_cnt, 0);
        tick();
        check_eq("hit_one_clk", hit_cnt, 1);
        check_eq("hit_pos_x", bullet_X, 10'd136);
        check_eq("hit_stops_flight", is_shooting, 1'b0);
        for (int k = 1; k <= 15; k++) begin
            press(); tick();
            check_eq($sformatf("cooldown_tick%0d", k), is_shooting, 1'b0);
        end
        press(); tick();
        check_eq("after_cooldown_launch", is_shooting, 1'b1);
        check_eq("after_cooldown_x", bullet_X, 10'd124);

        // Hit takes priority over leaving the screen.
        do_reset();
        targetX = 10'd630; targetY = 10'd100;
        tankX = 10'd597; tankY = 10'd100; tank_dir = 3'b010;
        press(); tick();
        check_eq("prio_spawn_x", bullet_X, 10'd629);
        hit_cnt = 0;
        tick();
        check_eq("prio_hit", hit_cnt, 1);
        check_eq("prio_hit_x", bullet_X, 10'd633);
        check_eq("prio_hit_y", bullet_Y, 10'd112);

        // Held fire launches once; a new press waits for the bullet to retire.
        do_reset();
        targetX = 10'd400; targetY = 10'd400;
        tankX = 10'd100; tankY = 10'd40; tank_dir = 3'b001;
        @(negedge Clk) fire = 1'b1;
        ticks(5);
        check_eq("held_flying", is_shooting, 1'b1);
        check_eq("held_y", bullet_Y, 10'd16);
        @(negedge Clk) fire = 1'b0;
        ticks(5);
        check_eq("held_retired", is_shooting, 1'b0);
        tick();
        check_eq("held_no_retrigger", is_shooting, 1'b0);
        press(); tick();
        check_eq("second_launch_y", bullet_Y, 10'd32);
        press(); tick();
        check_eq("press_in_flight_y", bullet_Y, 10'd28);
        check_eq("press_in_flight_shooting", is_shooting, 1'b1);
        ticks(8);
        check_eq("pending_retired", is_shooting, 1'b0);
        tick();
        check_eq("pending_relaunch", is_shooting, 1'b1);
        check_eq("pending_relaunch_y", bullet_Y, 10'd32);

        $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
        $finish;
    end

endmodule
